// File: rtl/fp_accum_pipe.sv
// fp_accum_pipe: multi-lane, 3-stage pipelined adder, FP32 A + narrow B -> FP32.
//   B is sign + 8-bit exponent + B_MAN_W-bit fraction (bf16 by default).
//   Per-lane accumulate mode replaces A with the lane accumulator (or +0).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_a, in_b          per-lane operands (lane i at [W*i +: W])
//   acc_mode, acc_first beat qualifiers, sampled with the beat
//   out_valid/out_ready result handshake
//   out_data            per-lane FP32 sum
//   acc_data            per-lane accumulator
//   dbg_state           accumulate FSM state (0 = IDLE, 1 = BUSY)
// Handshake: a beat transfers on a rising edge where valid & ready are both 1;
//   valid never depends on ready, and data is held stable while valid & !ready.
module fp_accum_pipe #(
  parameter int LANES   = 4,
  parameter int B_MAN_W = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*32-1:0]        in_a,
  input  logic [LANES*(9+B_MAN_W)-1:0] in_b,
  input  logic                       acc_mode,
  input  logic                       acc_first,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*32-1:0]        out_data,
  output logic [LANES*32-1:0]        acc_data,
  output logic                       dbg_state
);
  localparam int BW = 9 + B_MAN_W;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} acc_state_t;
  acc_state_t r_state, w_state_nxt;

  logic w_advance, w_accept, w_retire;
  logic r_v1, r_v2, r_v3;
  logic r_acc1, r_acc2, r_acc3;

  // One global stall: every stage moves together when the output is free.
  assign w_advance = !r_v3 | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_retire  = r_v3 & out_ready;
  assign out_valid = r_v3;
  assign dbg_state = r_state;

  // Accumulate FSM: blocks new beats while an acc beat is in flight so the
  // next one reads the written-back accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && acc_mode) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_retire && r_acc3)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = w_advance && (r_state == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r_acc1 <= 1'b0; r_acc2 <= 1'b0; r_acc3 <= 1'b0;
    end else if (w_advance) begin
      r_v1   <= w_accept;
      r_acc1 <= w_accept & acc_mode;
      r_v2   <= r_v1;
      r_acc2 <= r_acc1;
      r_v3   <= r_v2;
      r_acc3 <= r_acc2;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0]   r_acc;
    logic [31:0]   w_a;
    logic [BW-1:0] w_b;
    logic          w_sa, w_sb;
    logic [7:0]    w_ea, w_eb, w_xa, w_xb, w_e_big, w_e_sml, w_diff;
    logic [22:0]   w_fa, w_fb;
    logic [23:0]   w_ma, w_mb, w_m_big, w_m_sml;
    logic          w_a_big, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_spec;
    logic [31:0]   w_spec_val;
    logic [4:0]    w_sh;
    logic [49:0]   w_wide;
    logic [26:0]   w_aln;
    // S1 registers
    logic          r1_sign, r1_sub, r1_spec;
    logic [7:0]    r1_exp;
    logic [26:0]   r1_big, r1_sml;
    logic [31:0]   r1_spec_val;
    // S2 registers
    logic [27:0]   w_sum;
    logic          r2_sign, r2_spec;
    logic [7:0]    r2_exp;
    logic [27:0]   r2_sum;
    logic [31:0]   r2_spec_val;
    // S3
    logic [4:0]    w_lz, w_shl;
    logic [9:0]    w_exp_m1, w_exp_n, w_exp_f;
    logic [26:0]   w_norm;
    logic          w_inc;
    logic [24:0]   w_rnd;
    logic [22:0]   w_frac;
    logic [31:0]   w_res, r3_res;

    // S1: unpack, specials, compare, align (mantissa | guard | round | sticky)
    always_comb begin
      w_a  = acc_mode ? (acc_first ? 32'd0 : r_acc) : in_a[g*32 +: 32];
      w_b  = in_b[g*BW +: BW];
      w_sa = w_a[31];
      w_ea = w_a[30:23];
      w_fa = w_a[22:0];
      w_sb = w_b[BW-1];
      w_eb = w_b[BW-2 -: 8];
      w_fb = 23'(w_b[B_MAN_W-1:0]) << (23 - B_MAN_W);
      w_xa = (w_ea == 8'd0) ? 8'd1 : w_ea;
      w_xb = (w_eb == 8'd0) ? 8'd1 : w_eb;
      w_ma = {w_ea != 8'd0, w_fa};
      w_mb = {w_eb != 8'd0, w_fb};
      w_a_big = {w_xa, w_ma} >= {w_xb, w_mb};
      w_e_big = w_a_big ? w_xa : w_xb;
      w_e_sml = w_a_big ? w_xb : w_xa;
      w_m_big = w_a_big ? w_ma : w_mb;
      w_m_sml = w_a_big ? w_mb : w_ma;
      w_diff  = w_e_big - w_e_sml;
      // Shifts of 26 or more all collapse into the sticky bit.
      w_sh    = (w_diff >= 8'd26) ? 5'd26 : w_diff[4:0];
      w_wide  = {w_m_sml, 26'd0} >> w_sh;
      w_aln   = {w_wide[49:24], |w_wide[23:0]};
      w_nan_a = (w_ea == 8'hFF) && (w_fa != 23'd0);
      w_nan_b = (w_eb == 8'hFF) && (w_fb != 23'd0);
      w_inf_a = (w_ea == 8'hFF) && (w_fa == 23'd0);
      w_inf_b = (w_eb == 8'hFF) && (w_fb == 23'd0);
      w_spec  = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
      if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb)))
        w_spec_val = 32'h7FC00000;
      else if (w_inf_a)
        w_spec_val = {w_sa, 31'h7F800000};
      else
        w_spec_val = {w_sb, 31'h7F800000};
    end

    // S2: magnitude add/sub; big >= small so the result is never negative.
    always_comb begin
      if (r1_sub) w_sum = {1'b0, r1_big} - {1'b0, r1_sml};
      else        w_sum = {1'b0, r1_big} + {1'b0, r1_sml};
    end

    // S3: normalise (left shift limited so exponent never drops below 1),
    // round to nearest even, pack.
    always_comb begin
      w_lz = 5'd27;
      for (int i = 0; i < 27; i++) if (r2_sum[i]) w_lz = 5'(26 - i);
      w_exp_m1 = {2'b0, r2_exp} - 10'd1;
      w_shl    = 5'd0;
      if (r2_sum[27]) begin
        w_norm  = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
        w_exp_n = {2'b0, r2_exp} + 10'd1;
      end else begin
        w_shl   = ({5'd0, w_lz} > w_exp_m1) ? w_exp_m1[4:0] : w_lz;
        w_norm  = r2_sum[26:0] << w_shl;
        w_exp_n = {2'b0, r2_exp} - {5'd0, w_shl};
      end
      w_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
      if (w_rnd[24]) begin
        w_exp_f = w_exp_n + 10'd1;
        w_frac  = 23'd0;
      end else begin
        // Without the hidden bit the value is subnormal: exponent field 0.
        w_exp_f = w_rnd[23] ? w_exp_n : 10'd0;
        w_frac  = w_rnd[22:0];
      end
      if (w_exp_f >= 10'd255) w_res = {r2_sign, 31'h7F800000};
      else                    w_res = {r2_sign, w_exp_f[7:0], w_frac};
      if (r2_spec) w_res = r2_spec_val;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r1_sign <= 1'b0; r1_sub <= 1'b0; r1_spec <= 1'b0; r1_exp <= 8'd0;
        r1_big <= 27'd0; r1_sml <= 27'd0; r1_spec_val <= 32'd0;
        r2_sign <= 1'b0; r2_spec <= 1'b0; r2_exp <= 8'd0;
        r2_sum <= 28'd0; r2_spec_val <= 32'd0;
        r3_res <= 32'd0;
      end else if (w_advance) begin
        r1_sign     <= w_a_big ? w_sa : w_sb;
        r1_sub      <= w_sa ^ w_sb;
        r1_spec     <= w_spec;
        r1_exp      <= w_e_big;
        r1_big      <= {w_m_big, 3'b000};
        r1_sml      <= w_aln;
        r1_spec_val <= w_spec_val;
        // Exact cancellation of opposite signs is +0.
        r2_sign     <= (r1_sub && (w_sum == 28'd0)) ? 1'b0 : r1_sign;
        r2_spec     <= r1_spec;
        r2_exp      <= r1_exp;
        r2_sum      <= w_sum;
        r2_spec_val <= r1_spec_val;
        r3_res      <= w_res;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_acc <= 32'd0;
      else if (w_retire && r_acc3) r_acc <= r3_res;
    end

    assign out_data[g*32 +: 32] = r3_res;
    assign acc_data[g*32 +: 32] = r_acc;
  end
endmodule

// File: tb/tb_fp_accum_pipe.sv
// tb_fp_accum_pipe: directed self-checking bench for fp_accum_pipe (4 lanes, bf16 B).
module tb_fp_accum_pipe;
  localparam int LANES   = 4;
  localparam int B_MAN_W = 7;
  localparam int BW      = 9 + B_MAN_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_a = '0;
  logic [LANES*BW-1:0]   in_b = '0;
  logic                  acc_mode = 1'b0;
  logic                  acc_first = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [LANES*32-1:0]   out_data;
  logic [LANES*32-1:0]   acc_data;
  logic                  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [LANES*32-1:0] exp_q[$];

  fp_accum_pipe #(.LANES(LANES), .B_MAN_W(B_MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .acc_mode(acc_mode), .acc_first(acc_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_data(acc_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic [31:0] a, input logic [BW-1:0] b);
    in_a = {LANES{a}};
    in_b = {LANES{b}};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) tick();
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    n_total++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_total++; if (acc_data !== '0) begin n_bad++; $display("FAIL reset_acc_data got=%h want=0", acc_data); end
    n_total++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL reset_state got=%0b want=0", dbg_state); end
    rst = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_basic_add();
    out_ready = 1'b1; acc_mode = 1'b0;
    in_a = {32'h40400000, 32'h40400000, 32'h40400000, 32'h3F800000};
    in_b = {16'hBF80, 16'hBF80, 16'hBF80, 16'h3F80};
    in_valid = 1'b1;
    tick();                       // accepting edge
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1 got=%0b want=0", out_valid); end
    tick();
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat2 got=%0b want=0", out_valid); end
    tick();
    n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_lat3 got=%0b want=1", out_valid); end
    n_total++; if (out_data !== {4{32'h40000000}}) begin n_bad++; $display("FAIL basic_data got=%h want=%h", out_data, {4{32'h40000000}}); end
    tick();
  endtask

  task automatic test_vectors();
    logic [31:0] va [12] = '{32'h4B800000, 32'h4B800000, 32'h4B800000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h7F800000, 32'h00000001, 32'h7F800001,
                             32'h3F800000, 32'hC0400000, 32'h00C00000, 32'h3F800000};
    logic [15:0] vb [12] = '{16'h3F80, 16'h4040, 16'h3F40, 16'hBF80,
                             16'h7F7F, 16'hFF80, 16'h0000, 16'h3F80,
                             16'hFF80, 16'h3F80, 16'h8080, 16'h33C0};
    logic [31:0] ve [12] = '{32'h4B800000, 32'h4B800002, 32'h4B800000, 32'h00000000,
                             32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h7FC00000,
                             32'hFF800000, 32'hC0000000, 32'h00400000, 32'h3F800001};
    out_ready = 1'b1; acc_mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int waited;
      set_ops(va[k], vb[k]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      waited = 0;
      while (!out_valid && waited < 10) begin tick(); waited++; end
      n_total++;
      if (!out_valid) begin
        n_bad++; $display("FAIL vec%0d_timeout out_valid=%0b want=1", k, out_valid);
      end else if (out_data !== {LANES{ve[k]}}) begin
        n_bad++; $display("FAIL vec%0d got=%h want=%h", k, out_data, {LANES{ve[k]}});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] r_tab [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000};
    int sent = 0;
    int got = 0;
    int extra = 0;
    logic stalled_prev = 1'b0;
    logic [LANES*32-1:0] held = '0;
    logic [LANES*32-1:0] want;
    exp_q.delete();
    acc_mode = 1'b0; acc_first = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (stalled_prev) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_data, held);
        end
      end
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = (sent < 6);
      if (sent < 6) set_ops(a_tab[sent], 16'h3F80);
      #1;
      if (out_valid && !out_ready) begin
        n_total++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready cyc=%0d got=%0b want=0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_dup cyc=%0d got=%h want=none", cyc, out_data);
        end else begin
          want = exp_q.pop_front();
          if (out_data !== want) begin n_bad++; $display("FAIL stream_data cyc=%0d got=%h want=%h", cyc, out_data, want); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({LANES{r_tab[sent]}});
        sent++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_total++;
    if (got != 6 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL stream_count got=%0d left=%0d want=6/0", got, exp_q.size());
    end
    repeat (4) begin if (out_valid) extra++; tick(); end
    n_total++; if (extra != 0) begin n_bad++; $display("FAIL stream_extra got=%0d want=0", extra); end
  endtask

  task automatic test_accumulate();
    logic [31:0] part [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    out_ready = 1'b1;
    set_ops(32'h44444444, 16'h3F80);   // A must be ignored in acc mode
    acc_mode = 1'b1;
    in_valid = 1'b1;                    // held high: BUSY alone must block beats
    for (int k = 0; k < 4; k++) begin
      acc_first = (k == 0);
      n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL acc%0d_ready_pre got=%0b want=1", k, in_ready); end
      tick();                           // accepting edge
      acc_first = 1'b0;
      for (int j = 0; j < 3; j++) begin
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL acc%0d_busy%0d got=%0b want=0", k, j, in_ready); end
        if (j == 2) begin
          n_total++;
          if (out_valid !== 1'b1 || out_data !== {LANES{part[k]}}) begin
            n_bad++; $display("FAIL acc%0d_out got=%b/%h want=1/%h", k, out_valid, out_data, {LANES{part[k]}});
          end
        end
        tick();
      end
      if (k == 3) in_valid = 1'b0;
      n_total++; if (acc_data !== {LANES{part[k]}}) begin n_bad++; $display("FAIL acc%0d_data got=%h want=%h", k, acc_data, {LANES{part[k]}}); end
    end
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL acc_idle got=%0b want=1", in_ready); end
    // Non-acc beat after the reduction: normal result, accumulator untouched.
    acc_mode = 1'b0;
    set_ops(32'h3F800000, 16'h3F80);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_total++; if (out_data !== {LANES{32'h40000000}}) begin n_bad++; $display("FAIL nonacc_out got=%h want=%h", out_data, {LANES{32'h40000000}}); end
    tick();
    n_total++; if (acc_data !== {LANES{32'h40800000}}) begin n_bad++; $display("FAIL nonacc_keep got=%h want=%h", acc_data, {LANES{32'h40800000}}); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    acc_mode = 1'b0; acc_first = 1'b0;
    set_ops(32'h3F800000, 16'h3F80);
    in_valid = 1'b1;
    tick(); tick();                     // two plain beats
    acc_mode = 1'b1;
    tick();                             // acc beat, FSM goes BUSY
    in_valid = 1'b0; acc_mode = 1'b0;
    n_total++; if (out_valid !== 1'b1 || dbg_state !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%b/%b want=1/1", out_valid, dbg_state); end
    #2 rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
    n_total++; if (acc_data !== '0) begin n_bad++; $display("FAIL mid_acc_data got=%h want=0", acc_data); end
    n_total++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL mid_state got=%0b want=0", dbg_state); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready got=%0b want=1", in_ready); end
    repeat (6) begin if (out_valid) seen++; tick(); end
    n_total++; if (seen != 0) begin n_bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_basic_add();
    test_vectors();
    test_back_to_back();
    test_accumulate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
